// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU LSU (0)
// and the debug/DMA loader (1); one request per two cycles, one-cycle response pulse.

module data_memory_arbiter_resp_slot (
    input  logic        clock,
    input  logic        reset,
    input  logic        fire,
    input  logic        fire_error,
    input  logic [31:0] fire_rdata,
    output logic        valid,
    output logic        error,
    output logic [31:0] rdata
);
    // error/rdata hold until the next response to this requester
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            error <= 1'b0;
            rdata <= '0;
        end else begin
            valid <= fire;
            if (fire) begin
                error <= fire_error;
                rdata <= fire_rdata;
            end
        end
    end
endmodule

module data_memory_arbiter #(
    parameter int MEM_DEPTH = 2048
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_write,
    input  logic [29:0] req0_address,
    input  logic [31:0] req0_wdata,
    output logic        resp0_valid,
    output logic        resp0_error,
    output logic [31:0] resp0_rdata,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_write,
    input  logic [29:0] req1_address,
    input  logic [31:0] req1_wdata,
    output logic        resp1_valid,
    output logic        resp1_error,
    output logic [31:0] resp1_rdata,

    output logic [29:0] mem_address,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_input,
    input  logic [31:0] mem_read_result
);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam int NUM_REQ = 2;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, next_state;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_write;
    logic [NUM_REQ-1:0][29:0] req_address;
    logic [NUM_REQ-1:0][31:0] req_wdata;
    logic [NUM_REQ-1:0]       ready;

    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ-1:0]       resp_error;
    logic [NUM_REQ-1:0][31:0] resp_rdata;

    logic        gnt_id;
    logic        accept;
    logic        last_grant;
    logic [29:0] sel_address;
    logic        sel_error;

    logic [29:0] lat_address;
    logic        lat_write;
    logic [31:0] lat_wdata;
    logic        lat_id;
    logic        lat_error;

    logic        in_access;
    logic [31:0] load_rdata;

    assign req_valid   = {req1_valid, req0_valid};
    assign req_write   = {req1_write, req0_write};
    assign req_address = {req1_address, req0_address};
    assign req_wdata   = {req1_wdata, req0_wdata};

    assign req0_ready  = ready[0];
    assign req1_ready  = ready[1];
    assign resp0_valid = resp_valid[0];
    assign resp0_error = resp_error[0];
    assign resp0_rdata = resp_rdata[0];
    assign resp1_valid = resp_valid[1];
    assign resp1_error = resp_error[1];
    assign resp1_rdata = resp_rdata[1];

    // Ties go to whoever did not win last; a lone requester always wins.
    always_comb begin
        next_state = state;
        ready      = '0;
        gnt_id     = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid == 2'b11) gnt_id = ~last_grant;
                else                    gnt_id = req_valid[1];
                if (|req_valid) begin
                    ready[gnt_id] = 1'b1;
                    accept        = 1'b1;
                    next_state    = ACCESS;
                end
            end
            ACCESS:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign sel_address = req_address[gnt_id];
    assign sel_error   = (sel_address >> IDX_W) != '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // last_grant resets to 1 so requester 0 wins the first contended grant
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant  <= 1'b1;
            lat_address <= '0;
            lat_write   <= 1'b0;
            lat_wdata   <= '0;
            lat_id      <= 1'b0;
            lat_error   <= 1'b0;
        end else if (accept) begin
            last_grant  <= gnt_id;
            lat_address <= sel_address;
            lat_write   <= req_write[gnt_id];
            lat_wdata   <= req_wdata[gnt_id];
            lat_id      <= gnt_id;
            lat_error   <= sel_error;
        end
    end

    assign in_access = (state == ACCESS);

    // Latched registers only move on accept, so the address/data hold through IDLE.
    assign mem_address      = lat_address;
    assign mem_write_input  = lat_wdata;
    assign mem_write_enable = in_access && lat_write && !lat_error;

    assign load_rdata = (!lat_write && !lat_error) ? mem_read_result : '0;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_resp
        data_memory_arbiter_resp_slot u_slot (
            .clock      (clock),
            .reset      (reset),
            .fire       (in_access && (lat_id == 1'(i))),
            .fire_error (lat_error),
            .fire_rdata (load_rdata),
            .valid      (resp_valid[i]),
            .error      (resp_error[i]),
            .rdata      (resp_rdata[i])
        );
    end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: transaction-level reference model checked
// every cycle, plus literal expectations for the key scenarios.

module tb_data_memory_arbiter;
    localparam int MEM_DEPTH = 2048;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 0, req0_write = 0, req1_valid = 0, req1_write = 0;
    logic [29:0] req0_address = '0, req1_address = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready;
    logic        resp0_valid, resp0_error, resp1_valid, resp1_error;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic [29:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_input;
    logic [31:0] mem_read_result;

    logic [31:0] mem     [0:MEM_DEPTH-1];
    logic [31:0] ref_mem [0:MEM_DEPTH-1];

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;
    int dut_grants[$];

    data_memory_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .req0_valid       (req0_valid),
        .req0_ready       (req0_ready),
        .req0_write       (req0_write),
        .req0_address     (req0_address),
        .req0_wdata       (req0_wdata),
        .resp0_valid      (resp0_valid),
        .resp0_error      (resp0_error),
        .resp0_rdata      (resp0_rdata),
        .req1_valid       (req1_valid),
        .req1_ready       (req1_ready),
        .req1_write       (req1_write),
        .req1_address     (req1_address),
        .req1_wdata       (req1_wdata),
        .resp1_valid      (resp1_valid),
        .resp1_error      (resp1_error),
        .resp1_rdata      (resp1_rdata),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_input  (mem_write_input),
        .mem_read_result  (mem_read_result)
    );

    always #5 clock = ~clock;

    // Attached memory: combinational read, write on the falling edge.
    assign mem_read_result = mem[mem_address[10:0]];
    always @(negedge clock) if (mem_write_enable) mem[mem_address[10:0]] <= mem_write_input;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Who the spec says wins: lone requester, else the one that did not win last.
    function automatic int pick(input logic v0, input logic v1, input logic lg);
        if (v0 && v1) return (lg == 1'b1) ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Reference model: one outstanding transaction, responses per requester.
    logic        m_busy, m_id, m_wr, m_err, m_lg;
    logic [29:0] m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_rv, m_re;
    logic [31:0] m_rd [2];

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_lg <= 1'b1; m_rv <= 2'b00; m_re <= 2'b00;
            m_rd[0] <= '0; m_rd[1] <= '0;
        end else if (m_busy) begin
            m_rv <= 2'b01 << m_id;
            m_re[m_id] <= m_err;
            m_rd[m_id] <= (!m_wr && !m_err) ? ref_mem[m_addr[10:0]] : 32'h0;
            if (m_wr && !m_err) ref_mem[m_addr[10:0]] <= m_data;
            m_busy <= 1'b0;
        end else begin
            m_rv <= 2'b00;
            if (pick(req0_valid, req1_valid, m_lg) >= 0) begin
                m_busy <= 1'b1;
                m_id   <= (pick(req0_valid, req1_valid, m_lg) == 1);
                m_lg   <= (pick(req0_valid, req1_valid, m_lg) == 1);
                m_wr   <= (pick(req0_valid, req1_valid, m_lg) == 1) ? req1_write : req0_write;
                m_addr <= (pick(req0_valid, req1_valid, m_lg) == 1) ? req1_address : req0_address;
                m_data <= (pick(req0_valid, req1_valid, m_lg) == 1) ? req1_wdata : req0_wdata;
                m_err  <= ((pick(req0_valid, req1_valid, m_lg) == 1) ? req1_address : req0_address) >= MEM_DEPTH;
            end
        end
    end

    // Per-cycle compare, sampled well away from both clock edges.
    always @(posedge clock) begin
        #4;
        if (reset && chk_en) begin
            check("req0_ready", req0_ready, !m_busy && pick(req0_valid, req1_valid, m_lg) == 0);
            check("req1_ready", req1_ready, !m_busy && pick(req0_valid, req1_valid, m_lg) == 1);
            check("ready_exclusive", req0_ready & req1_ready, 0);
            check("mem_write_enable", mem_write_enable, m_busy && m_wr && !m_err);
            if (m_busy) check("mem_address", mem_address, m_addr);
            if (m_busy && m_wr) check("mem_write_input", mem_write_input, m_data);
            check("resp0_valid", resp0_valid, m_rv[0]);
            check("resp0_error", resp0_error, m_re[0]);
            check("resp0_rdata", resp0_rdata, m_rd[0]);
            check("resp1_valid", resp1_valid, m_rv[1]);
            check("resp1_error", resp1_error, m_re[1]);
            check("resp1_rdata", resp1_rdata, m_rd[1]);
            if (req0_valid && req0_ready) dut_grants.push_back(0);
            if (req1_valid && req1_ready) dut_grants.push_back(1);
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic set_req(input int id, input logic v, input logic wr,
                           input logic [29:0] addr, input logic [31:0] data);
        if (id == 0) begin
            req0_valid = v; req0_write = wr; req0_address = addr; req0_wdata = data;
        end else begin
            req1_valid = v; req1_write = wr; req1_address = addr; req1_wdata = data;
        end
    endtask

    // Called 1ns after an edge; returns 1ns after the accepting edge.
    task automatic do_req(input int id, input logic wr, input logic [29:0] addr, input logic [31:0] data);
        bit done = 0;
        set_req(id, 1'b1, wr, addr, data);
        for (int k = 0; k < 20 && !done; k++) begin
            #3;
            done = (id == 0) ? req0_ready : req1_ready;
            @(posedge clock); #1;
        end
        set_req(id, 1'b0, 1'b0, '0, '0);
        check("handshake_timeout", done, 1);
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] = i * 32'h11;
            ref_mem[i] = i * 32'h11;
        end
        mem[0] = 32'hCAFE0000;
        ref_mem[0] = 32'hCAFE0000;

        // Reset state
        #2;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_resp0_valid", resp0_valid, 0);
        check("rst_resp1_valid", resp1_valid, 0);
        check("rst_resp0_rdata", resp0_rdata, 0);
        check("rst_mem_we", mem_write_enable, 0);

        // Both requesters load continuously out of reset
        set_req(0, 1'b1, 1'b0, 30'd1, '0);
        set_req(1, 1'b1, 1'b0, 30'd2, '0);
        tick();
        reset = 1'b1;
        chk_en = 1;
        repeat (8) tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        check("contend_grant_count", dut_grants.size(), 4);
        if (dut_grants.size() == 4) begin
            check("contend_grant0", dut_grants[0], 0);
            check("contend_grant1", dut_grants[1], 1);
            check("contend_grant2", dut_grants[2], 0);
            check("contend_grant3", dut_grants[3], 1);
        end
        check("contend_resp0_rdata", resp0_rdata, 32'h11);
        check("contend_resp1_rdata", resp1_rdata, 32'h22);
        tick();

        // Store then load word 5 from requester 0
        do_req(0, 1'b1, 30'd5, 32'hDEADBEEF);
        check("store_mem_we", mem_write_enable, 1);
        do_req(0, 1'b0, 30'd5, '0);
        check("load_not_yet", resp0_valid, 0);
        tick();
        check("load_resp_valid", resp0_valid, 1);
        check("load_resp_rdata", resp0_rdata, 32'hDEADBEEF);
        check("load_resp_error", resp0_error, 0);
        tick();
        check("load_resp_pulse", resp0_valid, 0);
        check("load_rdata_hold", resp0_rdata, 32'hDEADBEEF);
        check("mem5_written", mem[5], 32'hDEADBEEF);

        // Out-of-range store from requester 1
        do_req(1, 1'b1, 30'h800, 32'h5555AAAA);
        check("oor_mem_we", mem_write_enable, 0);
        tick();
        check("oor_resp_valid", resp1_valid, 1);
        check("oor_resp_error", resp1_error, 1);
        check("oor_resp_rdata", resp1_rdata, 0);
        do_req(1, 1'b0, 30'd0, '0);
        tick();
        check("word0_unchanged", resp1_rdata, 32'hCAFE0000);
        check("word0_load_error", resp1_error, 0);

        // Requester 0 alone, four back-to-back loads
        dut_grants.delete();
        set_req(0, 1'b1, 1'b0, 30'd7, '0);
        repeat (8) tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        check("solo_grant_count", dut_grants.size(), 4);
        foreach (dut_grants[k]) check("solo_grant_id", dut_grants[k], 0);
        check("solo_rdata", resp0_rdata, 32'h77);

        // last_grant is now 0, so requester 1 wins the next tie
        dut_grants.delete();
        set_req(0, 1'b1, 1'b0, 30'd1, '0);
        set_req(1, 1'b1, 1'b0, 30'd2, '0);
        repeat (2) tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        check("after_solo_count", dut_grants.size(), 1);
        if (dut_grants.size() >= 1) check("after_solo_grant", dut_grants[0], 1);
        tick();

        // Reset in the middle of a store to word 3
        do_req(0, 1'b1, 30'd3, 32'h12345678);
        check("pre_reset_we", mem_write_enable, 1);
        #1;
        reset = 1'b0;
        #1;
        check("reset_we_drop", mem_write_enable, 0);
        set_req(0, 1'b1, 1'b0, 30'd1, '0);
        set_req(1, 1'b1, 1'b0, 30'd2, '0);
        tick();
        check("reset_no_resp0", resp0_valid, 0);
        check("reset_no_resp1", resp1_valid, 0);
        check("word3_not_written", mem[3], 32'h33);
        tick();
        dut_grants.delete();
        reset = 1'b1;
        repeat (2) tick();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        check("post_reset_count", dut_grants.size(), 1);
        if (dut_grants.size() >= 1) check("post_reset_grant", dut_grants[0], 0);
        check("post_reset_rdata", resp0_rdata, 32'h11);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares one single-port data memory between two requesters: requester 0 is the CPU load/store unit, requester 1 is the debug/DMA loader.
- Sits between the requesters and the data memory, driving its address, write-enable and write-data inputs and sampling its combinational read result.
- Uses round-robin arbitration, a valid/ready request handshake and a one-cycle response pulse per requester.
- Detects and flags out-of-range accesses so the memory is never written with an invalid address.

Parameters:
- MEM_DEPTH, 2048, number of 32-bit words in the attached memory; the valid word index is address[$clog2(MEM_DEPTH)+1:2] with all higher bits zero.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- For each requester N=0,1:
  - reqN_valid  input  1  request present.
  - reqN_ready  output  1  request accepted this cycle (combinational).
  - reqN_write  input  1  1=store, 0=load.
  - reqN_address  input  30  word address [31:2].
  - reqN_wdata  input  32  store data.
  - respN_valid  output  1  one-cycle response pulse.
  - respN_error  output  1  qualifies respN_valid; 1 means the address was out of range.
  - respN_rdata  output  32  load data; 0 for stores and errors.
- mem_address  output  30  word address to the memory.
- mem_write_enable  output  1  memory write strobe; the memory writes on the negedge within the ACCESS cycle.
- mem_write_input  output  32  data to the memory.
- mem_read_result  input  32  combinational read data from the memory.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - Latched request registers (address, write, data, id, error), respN_valid, respN_error and respN_rdata all clear to 0.
  - mem_write_enable is forced low immediately.
  - An in-flight access is dropped: no response pulse and no write after reset asserts.
- FSM has two states: IDLE and ACCESS.
- IDLE:
  - The grant is computed combinationally.
    - Only one reqN_valid=1: that N is granted.
    - Both valid: grant goes to ~last_grant.
  - reqN_ready=1 only for the granted N, and only while in IDLE. Handshake completes when reqN_valid and reqN_ready are both 1 at the posedge.
  - On that posedge:
    - Latch address, write, wdata and id.
    - Compute error = (address bits above the valid index are not all zero).
    - Set last_grant=id and go to ACCESS.
  - No valid request: remain in IDLE with both readies at 0.
- ACCESS (exactly one cycle):
  - mem_address and mem_write_input are driven from the latched registers.
  - mem_write_enable = latched write AND NOT latched error.
  - On the posedge, go to IDLE and, for the latched id only, register:
    - respN_valid=1.
    - respN_error=latched error.
    - respN_rdata = mem_read_result for an in-range load; 0 otherwise.
  - All reqN_ready=0 during ACCESS.
- In IDLE, mem_write_enable=0; mem_address and mem_write_input hold their last values.
- respN_valid is high for exactly one cycle, in the IDLE cycle after ACCESS. respN_rdata and respN_error hold until the next response to that requester.
- Throughput is one request per 2 cycles. Load latency is 2 posedges from handshake to the response being visible.
- Request inputs may change freely while reqN_ready=0; the arbiter samples them only at the accepting edge.
- A requester that holds valid continuously alternates with the other requester. Neither waits more than one access under contention.
- Reset release: the first grant under contention goes to requester 0.

Test Plan:
- Requester 0 stores 0xDEADBEEF to word 5, then loads word 5 -> req0_ready high in each IDLE cycle; the store has mem_write_enable=1 for one cycle; the load gets resp0_valid with resp0_rdata=0xDEADBEEF, resp0_error=0, 2 edges after the handshake.
- Both requesters assert loads continuously from reset (req0 to word 1 = 0x11, req1 to word 2 = 0x22) -> grants are 0,1,0,1; responses alternate resp0=0x11 and resp1=0x22, one every 2 cycles; the readies are never high together.
- Requester 1 stores to word address 0x800 (MEM_DEPTH=2048) -> mem_write_enable stays 0; resp1_valid=1, resp1_error=1, resp1_rdata=0; memory contents unchanged (reload word 0 returns its prior value).
- Requester 0 alone issues 4 back-to-back loads -> each is accepted on alternate cycles with no requester-1 slots inserted; last_grant=0 afterwards.
- reset driven low mid-ACCESS on a store to word 3 -> mem_write_enable drops immediately; no resp pulse; after release the state is IDLE and the first contended grant goes to requester 0.
